led_seq_controller: RTL and testbench



---
 rtl/led_seq_pkg.sv | 25 ++
 rtl/led_seq_tick_counter.sv | 28 ++
 rtl/led_seq_controller.sv | 210 +++++++++++++++++++++
 tb/tb_led_seq_controller.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// led_seq_pkg: register map, CTRL/STATUS bit positions and FSM
// encoding shared by the LED pattern sequencer.
package led_seq_pkg;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_PERIOD = 3'd1;
  localparam logic [2:0] ADDR_STATUS = 3'd2;
  localparam logic [2:0] ADDR_PAT0   = 3'd4;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int CTRL_LEN     = 2;
  localparam int CTRL_IE      = 4;

  localparam int STAT_STEP = 0;
  localparam int STAT_BUSY = 2;
  localparam int STAT_WRAP = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    COUNT = 2'd2
  } state_t;

endpackage

// File: rtl/led_seq_tick_counter.sv
// led_seq_tick_counter: loadable down-counter with zero flag.
// Ports: clk, reset (sync, high), load/load_val, dec, zero.
module led_seq_tick_counter #(
  parameter int PERIOD_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                dec,
  input  logic [PERIOD_W-1:0] load_val,
  output logic                zero
);

  logic [PERIOD_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && !zero) begin
      cnt <= cnt - PERIOD_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/led_seq_controller.sv
// led_seq_controller: steps a 4-entry LED pattern table into a PIO
// data register over Avalon-MM at a programmable rate.
// Ports: clk, reset (sync, high); s_* config slave (3-bit word
// address, comb readdata); m_* PIO master (one-cycle write per
// step); irq wrap interrupt.
// Build option: LED_SEQ_IRQ_EN adds the wrap flag, IE bit and irq.
module led_seq_controller
  import led_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 2,
  parameter int PERIOD_W   = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  s_address,
  input  logic        s_chipselect,
  input  logic        s_write_n,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
  output logic        irq
);

  state_t state_q;
  state_t state_d;

  logic                  en_q;
  logic                  oneshot_q;
  logic [1:0]            len_m1_q;
  logic [PERIOD_W-1:0]   period_q;
  logic [DATA_WIDTH-1:0] pat_q [4];
  logic [1:0]            step_q;
  logic                  ie_q;
  logic                  wrap_q;
  logic                  cnt_zero;

  logic cfg_wr;
  logic ctrl_wr;
  logic stat_wr;
  logic per_wr;
  logic pat_hit;
  logic en_eff;
  logic last_step;
  logic step_adv;
  logic os_end;
  logic wrap_ev;

  assign cfg_wr  = s_chipselect && !s_write_n;
  assign pat_hit = (s_address >= ADDR_PAT0);
  assign ctrl_wr = cfg_wr && (s_address == ADDR_CTRL);
  assign stat_wr = cfg_wr && (s_address == ADDR_STATUS);
  assign per_wr  = cfg_wr && (s_address == ADDR_PERIOD);

  // A CTRL write in flight stops a running sequence at once,
  // so no extra PIO pulse follows a disable.
  assign en_eff = ctrl_wr ? s_writedata[CTRL_EN] : en_q;

  // step beyond a shrunken LEN also counts as the last step
  assign last_step = (step_q >= len_m1_q);
  assign step_adv  = (state_q == COUNT) && cnt_zero && en_eff;
  assign os_end    = step_adv && oneshot_q &&
                     (step_q == len_m1_q);
  assign wrap_ev   = step_adv && last_step;

  led_seq_tick_counter #(
    .PERIOD_W (PERIOD_W)
  ) u_tick (
    .clk      (clk),
    .reset    (reset),
    .load     (state_q == WRITE),
    .dec      (state_q == COUNT),
    .load_val (period_q),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (en_q) state_d = WRITE;
      end
      WRITE: begin
        state_d = en_eff ? COUNT : IDLE;
      end
      COUNT: begin
        if (!en_eff || os_end) begin
          state_d = IDLE;
        end else if (cnt_zero) begin
          state_d = WRITE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_chipselect = 1'b0;
    m_write_n    = 1'b1;
    m_writedata  = '0;
    if (state_q == WRITE) begin
      m_chipselect = 1'b1;
      m_write_n    = 1'b0;
      m_writedata[DATA_WIDTH-1:0] = pat_q[step_q];
    end
  end

  assign m_address = 2'b00;

  always_ff @(posedge clk) begin
    if (reset) begin
      step_q <= 2'd0;
    end else if (state_q == IDLE && en_q) begin
      step_q <= 2'd0;
    end else if (step_adv && !os_end) begin
      step_q <= last_step ? 2'd0 : step_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q      <= 1'b0;
      oneshot_q <= 1'b0;
      len_m1_q  <= 2'd0;
      period_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        pat_q[i] <= '0;
      end
    end else begin
      if (ctrl_wr) begin
        en_q      <= s_writedata[CTRL_EN];
        oneshot_q <= s_writedata[CTRL_ONESHOT];
        len_m1_q  <= s_writedata[CTRL_LEN +: 2];
      end else if (os_end) begin
        en_q <= 1'b0;
      end
      if (per_wr) begin
        period_q <= s_writedata[PERIOD_W-1:0];
      end
      if (cfg_wr && pat_hit) begin
        pat_q[s_address[1:0]] <=
          s_writedata[DATA_WIDTH-1:0];
      end
    end
  end

`ifdef LED_SEQ_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ie_q   <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        ie_q <= s_writedata[CTRL_IE];
      end
      // a new wrap beats a simultaneous clear
      if (wrap_ev) begin
        wrap_q <= 1'b1;
      end else if (stat_wr && s_writedata[STAT_WRAP]) begin
        wrap_q <= 1'b0;
      end
    end
  end

  assign irq = wrap_q & ie_q;
`else
  assign ie_q   = 1'b0;
  assign wrap_q = 1'b0;
  assign irq    = 1'b0;

  logic unused_wrap;
  assign unused_wrap = wrap_ev | stat_wr;
`endif

  always_comb begin
    s_readdata = '0;
    case (s_address)
      ADDR_CTRL: begin
        s_readdata[CTRL_EN]      = en_q;
        s_readdata[CTRL_ONESHOT] = oneshot_q;
        s_readdata[CTRL_LEN +: 2] = len_m1_q;
        s_readdata[CTRL_IE]      = ie_q;
      end
      ADDR_PERIOD: begin
        s_readdata[PERIOD_W-1:0] = period_q;
      end
      ADDR_STATUS: begin
        s_readdata[STAT_STEP +: 2] = step_q;
        s_readdata[STAT_BUSY]      = (state_q != IDLE);
        s_readdata[STAT_WRAP]      = wrap_q;
      end
      default: begin
        if (pat_hit) begin
          s_readdata[DATA_WIDTH-1:0] = pat_q[s_address[1:0]];
        end
      end
    endcase
  end

endmodule

// File: tb/tb_led_seq_controller.sv
// tb_led_seq_controller: directed scenarios plus random traffic,
// every cycle compared against a step/age reference model.
module tb_led_seq_controller;

  localparam int DW = 2;
  localparam int PW = 32;
`ifdef LED_SEQ_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  s_address;
  logic        s_chipselect;
  logic        s_write_n;
  logic [31:0] s_writedata;
  logic [31:0] s_readdata;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;
  logic        irq;

  always #5 clk = ~clk;

  led_seq_controller #(
    .DATA_WIDTH (DW),
    .PERIOD_W   (PW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .s_address    (s_address),
    .s_chipselect (s_chipselect),
    .s_write_n    (s_write_n),
    .s_writedata  (s_writedata),
    .s_readdata   (s_readdata),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_write_n    (m_write_n),
    .m_writedata  (m_writedata),
    .irq          (irq)
  );

  int checks   = 0;
  int failures = 0;
  int cyc_no   = 0;
  int pulse_t[$];
  logic [31:0] pulse_d[$];
  logic [31:0] last_rd;

  // reference model: registers plus "age" = cycles since the
  // current step's PIO write (age 0 is the write cycle itself)
  bit          m_en, m_os, m_ie, m_wrap, m_busy;
  bit   [1:0]  m_len, m_step;
  logic [31:0] m_period;
  logic [1:0]  m_pat [4];
  longint      m_age, m_perl;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [2:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      3'd0: begin
        r[0] = m_en; r[1] = m_os; r[3:2] = m_len; r[4] = m_ie;
      end
      3'd1: r = m_period;
      3'd2: begin
        r[1:0] = m_step; r[2] = m_busy; r[3] = m_wrap;
      end
      3'd3: r = '0;
      default: r[1:0] = m_pat[a[1:0]];
    endcase
    return r;
  endfunction

  function automatic bit wrap_pred();
    return m_busy && m_age != 0 && m_age == m_perl + 1 &&
           m_en && m_step >= m_len;
  endfunction

  task automatic model_step(input bit rst, input bit wr,
                            input logic [2:0] a, input logic [31:0] d);
    bit ctrl_wr, en_eff, wset, os_done;
    if (rst) begin
      m_en = 0; m_os = 0; m_ie = 0; m_wrap = 0; m_busy = 0;
      m_len = 0; m_step = 0; m_period = 0; m_age = 0; m_perl = 0;
      for (int i = 0; i < 4; i++) m_pat[i] = 2'd0;
      return;
    end
    ctrl_wr = wr && a == 3'd0;
    en_eff  = ctrl_wr ? d[0] : m_en;
    wset    = 0;
    os_done = 0;
    if (!m_busy) begin
      if (m_en) begin
        m_busy = 1; m_age = 0; m_step = 0;
      end
    end else if (!en_eff) begin
      m_busy = 0;
    end else if (m_age == 0) begin
      m_perl = longint'(m_period);
      m_age  = 1;
    end else if (m_age < m_perl + 1) begin
      m_age++;
    end else begin
      if (m_os && m_step == m_len) begin
        m_busy = 0; os_done = 1; wset = 1;
      end else begin
        if (m_step >= m_len) begin
          m_step = 0; wset = 1;
        end else begin
          m_step++;
        end
        m_age = 0;
      end
    end
    if (ctrl_wr) begin
      m_en = d[0]; m_os = d[1]; m_len = d[3:2]; m_ie = d[4] & IRQ;
    end else if (os_done) begin
      m_en = 0;
    end
    if (wr && a == 3'd1) m_period = d;
    if (wr && a >= 3'd4) m_pat[a[1:0]] = d[1:0];
    if (wset && IRQ) m_wrap = 1;
    else if (wr && a == 3'd2 && d[3]) m_wrap = 0;
  endtask

  task automatic cyc(input bit wr, input logic [2:0] a,
                     input logic [31:0] d);
    bit exp_cs;
    s_chipselect = 1'b1;
    s_write_n    = !wr;
    s_address    = a;
    s_writedata  = d;
    #1;
    last_rd = s_readdata;
    exp_cs  = m_busy && m_age == 0;
    check("m_chipselect", 32'(m_chipselect), 32'(exp_cs));
    check("m_write_n", 32'(m_write_n), 32'(!exp_cs));
    check("m_writedata", m_writedata,
          exp_cs ? {30'd0, m_pat[m_step]} : 32'd0);
    check("m_address", 32'(m_address), 32'd0);
    check("irq", 32'(irq), 32'(m_wrap & m_ie));
    check("s_readdata", s_readdata, m_read(a));
    if (m_chipselect === 1'b1) begin
      pulse_t.push_back(cyc_no);
      pulse_d.push_back(m_writedata);
    end
    model_step(reset, wr, a, d);
    cyc_no++;
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cyc(1'b1, a, d);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 3'($urandom_range(0, 7)), 32'd0);
  endtask

  task automatic wait_pulse(input int budget);
    for (int i = 0; i < budget && pulse_t.size() == 0; i++) idle(1);
  endtask

  initial begin
    int t_ctrl;
    int exp_d[5];
    logic [2:0]  ra;
    logic [31:0] rd;
    int r;
    exp_d = '{1, 2, 3, 0, 1};

    reset        = 1'b1;
    s_address    = '0;
    s_chipselect = 1'b0;
    s_write_n    = 1'b1;
    s_writedata  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    model_step(1'b1, 1'b0, 3'd0, 32'd0);
    cyc(1'b0, 3'd0, 32'd0);
    reset = 1'b0;

    // free-run 1,2,3,0 at PERIOD=3
    wr(3'd4, 1); wr(3'd5, 2); wr(3'd6, 3); wr(3'd7, 0);
    wr(3'd1, 3);
    pulse_t.delete(); pulse_d.delete();
    t_ctrl = cyc_no;
    wr(3'd0, 32'h0D);
    idle(24);
    check("t2_npulse", 32'(pulse_t.size() >= 5), 32'd1);
    if (pulse_t.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        check("t2_time", 32'(pulse_t[i] - t_ctrl), 32'(2 + 5 * i));
        check("t2_data", pulse_d[i], 32'(exp_d[i]));
      end
    end

    // reset mid-run
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    for (int a = 0; a < 8; a++) begin
      cyc(1'b0, 3'(a), 32'd0);
      check("t1_rd", last_rd, 32'd0);
    end
    check("t1_cs", 32'(m_chipselect), 32'd0);

    // oneshot of two steps at PERIOD=0
    wr(3'd4, 1); wr(3'd5, 2); wr(3'd6, 3); wr(3'd7, 0);
    wr(3'd1, 0);
    pulse_t.delete(); pulse_d.delete();
    wr(3'd0, 32'h07);
    idle(20);
    check("t3_npulse", 32'(pulse_t.size()), 32'd2);
    if (pulse_t.size() == 2) begin
      check("t3_d0", pulse_d[0], 32'd1);
      check("t3_d1", pulse_d[1], 32'd2);
    end
    cyc(1'b0, 3'd0, 32'd0);
    check("t3_en", 32'(last_rd[0]), 32'd0);
    cyc(1'b0, 3'd2, 32'd0);
    check("t3_busy", 32'(last_rd[2]), 32'd0);

    // stop during COUNT
    wr(3'd1, 3);
    pulse_t.delete(); pulse_d.delete();
    wr(3'd0, 32'h0D);
    wait_pulse(10);
    check("t4_start", 32'(pulse_t.size() > 0), 32'd1);
    idle(2);
    wr(3'd0, 32'h0C);
    pulse_t.delete(); pulse_d.delete();
    idle(100);
    check("t4_nopulse", 32'(pulse_t.size()), 32'd0);

    // PERIOD change mid-count
    wr(3'd1, 10);
    pulse_t.delete(); pulse_d.delete();
    wr(3'd0, 32'h0D);
    wait_pulse(10);
    idle(3);
    wr(3'd1, 2);
    idle(30);
    check("t5_npulse", 32'(pulse_t.size() >= 4), 32'd1);
    if (pulse_t.size() >= 4) begin
      check("t5_int0", 32'(pulse_t[1] - pulse_t[0]), 32'd12);
      check("t5_int1", 32'(pulse_t[2] - pulse_t[1]), 32'd4);
      check("t5_int2", 32'(pulse_t[3] - pulse_t[2]), 32'd4);
    end

`ifdef LED_SEQ_IRQ_EN
    // wrap interrupt, clear, and set-beats-clear
    wr(3'd0, 32'h00);
    idle(2);
    wr(3'd1, 1);
    wr(3'd0, 32'h15);
    for (int i = 0; i < 40 && irq !== 1'b1; i++) cyc(1'b0, 3'd2, 0);
    check("t6_irq_rise", 32'(irq), 32'd1);
    cyc(1'b0, 3'd2, 32'd0);
    check("t6_step", 32'(last_rd[1:0]), 32'd0);
    wr(3'd2, 32'h8);
    check("t6_irq_clr", 32'(irq), 32'd0);
    for (int i = 0; i < 20 && !wrap_pred(); i++) idle(1);
    wr(3'd2, 32'h8);
    check("t6_irq_hold", 32'(irq), 32'd1);
`endif

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
      end else if (r < 14) begin
        ra = 3'($urandom_range(0, 7));
        rd = $urandom;
        if (ra == 3'd1) rd = 32'($urandom_range(0, 5));
        wr(ra, rd);
      end else begin
        idle(1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
